jt12_sh_tap: RTL and testbench

Host-side access port for the time-multiplexed per-slot shift-register rings used throughout the FM core. It sits in series with a slot ring and tracks the slot index of the value currently passing. On request it either reads one slot's value out of the ring or overwrites one slot's value as it passes. This lets control logic inspect or patch per-operator state without a parallel register file.

---
 rtl/jt12_sh_tap.sv | 74 +++++++
 tb/tb_jt12_sh_tap.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jt12_sh_tap.sv
// jt12_sh_tap: host read/write access port sitting in series with a per-slot ring.
// Tracks the slot index passing through and reads or patches one slot on request.
module jt12_sh_tap #(
   parameter int   width  = 5,
   parameter int   stages = 24,
   parameter logic rstval = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_en,
   input  logic             sync,
   input  logic [width-1:0] din,
   output logic [width-1:0] dout,
   input  logic             rd_req,
   input  logic             wr_req,
   input  logic [4:0]       addr,
   input  logic [width-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [width-1:0] rdata
);
   typedef enum logic [1:0] {IDLE, RD_PEND, WR_PEND} state_t;
   localparam logic [4:0] LAST  = 5'(stages - 1);
   localparam logic [5:0] NSLOT = 6'(stages);
   state_t             state_q;
   logic [4:0]         cnt_q, cnt_d, addr_q, slot_cur;
   logic [width-1:0]   wdata_q, rdata_q;
   logic               done_q, err_q, match, bad;
   always_comb begin
      slot_cur = sync ? 5'd0 : cnt_q;
      cnt_d    = slot_cur == LAST ? 5'd0 : slot_cur + 5'd1;
      match    = clk_en && slot_cur == addr_q;
      bad      = {1'b0, addr} >= NSLOT;
      dout     = rst ? {width{rstval}} : (state_q == WR_PEND && match) ? wdata_q : din;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (clk_en) cnt_q <= cnt_d;
         if (state_q == IDLE) begin
            // a write wins over a simultaneous read; bad addresses are rejected at once
            if ((rd_req || wr_req) && bad) begin
               done_q <= 1'b1;
               err_q  <= 1'b1;
            end else if (wr_req) begin
               state_q <= WR_PEND;
               addr_q  <= addr;
               wdata_q <= wdata;
            end else if (rd_req) begin
               state_q <= RD_PEND;
               addr_q  <= addr;
            end
         end else if (match) begin
            if (state_q == RD_PEND) rdata_q <= din;
            state_q <= IDLE;
            done_q  <= 1'b1;
         end
      end
   end
   assign busy  = state_q != IDLE;
   assign done  = done_q;
   assign err   = err_q;
   assign rdata = rdata_q;
endmodule

// File: tb/tb_jt12_sh_tap.sv
// tb_jt12_sh_tap: randomized self-checking bench for jt12_sh_tap against a slot-position model.
module tb_jt12_sh_tap;
   localparam int   ST = 24;
   localparam logic RV = 1'b1;
   logic       clk = 1'b0, rst, clk_en, sync, rd_req, wr_req, busy, done, err;
   logic [4:0] din, dout, addr, wdata, rdata;
   int checks = 0, errors = 0;
   int m_pos = 0, m_kind = 0, m_addr = 0;
   logic [4:0] m_wdata = '0, m_rdata = '0;
   bit m_done = 0, m_err = 0;
   int e_cur;
   bit e_match, e_busy;
   logic [4:0] e_dout;

   jt12_sh_tap #(.width(5), .stages(ST), .rstval(RV)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .sync(sync), .din(din), .dout(dout),
      .rd_req(rd_req), .wr_req(wr_req), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .err(err), .rdata(rdata)
   );

   always #5 clk = ~clk;

   task automatic drive(input bit r, e, s, rq, wq, input logic [4:0] a, wd, d);
      rst = r; clk_en = e; sync = s; rd_req = rq; wr_req = wq; addr = a; wdata = wd; din = d;
   endtask

   // Expected outputs for the current cycle from the model's slot position and pending request.
   task automatic sample();
      @(negedge clk);
      e_cur   = sync ? 0 : m_pos % ST;
      e_match = m_kind != 0 && clk_en && e_cur == m_addr;
      e_dout  = rst ? {5{RV}} : (m_kind == 2 && e_match) ? m_wdata : din;
      e_busy  = m_kind != 0;
   endtask

   task automatic tick();
      bit nd, ne;
      @(posedge clk);
      nd = 0; ne = 0;
      if (rst) begin
         m_pos = 0; m_kind = 0; m_rdata = '0;
      end else begin
         if (e_match) begin
            if (m_kind == 1) m_rdata = din;
            m_kind = 0; nd = 1;
         end else if (m_kind == 0 && (rd_req || wr_req)) begin
            if (addr >= ST) begin nd = 1; ne = 1; end
            else begin m_kind = wr_req ? 2 : 1; m_addr = addr; m_wdata = wdata; end
         end
         if (clk_en) m_pos = e_cur + 1;
      end
      m_done = nd; m_err = ne;
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0, 1, 0, 5'd3, 5'd0, 5'($urandom));
         sample();
         checks++; if (dout !== e_dout) begin errors++; $display("FAIL rst_dout got %h exp %h", dout, e_dout); end
         if (i > 0) begin
            checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {busy, done, err}); end
            checks++; if (rdata !== 5'd0) begin errors++; $display("FAIL rst_rdata got %h exp 00", rdata); end
         end
         tick();
      end
      drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd9);
      sample();
      checks++; if (dut.slot_cur !== 5'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", dut.slot_cur); end
      checks++; if (dout !== 5'd9) begin errors++; $display("FAIL rst_release_dout got %h exp 09", dout); end
      tick();
   endtask

   task automatic test_slot_count();
      int ph;
      bit s;
      for (int i = 0; i < 80; i++) begin
         ph = m_pos % ST;
         s  = (i < 48 && ph == 0) || i == 60;
         drive(0, 1, s, 0, 0, 5'd0, 5'd0, s ? 5'd0 : 5'(ph));
         sample();
         checks++; if (dut.slot_cur !== 5'(e_cur) || din !== 5'(e_cur)) begin errors++; $display("FAIL slot_cur got %0d exp %0d", dut.slot_cur, e_cur); end
         checks++; if (dout !== din) begin errors++; $display("FAIL slot_dout got %h exp %h", dout, din); end
         tick();
      end
   endtask

   task automatic test_read();
      int ph, nb;
      bit issued, got, rq;
      nb = 0; issued = 0; got = 0;
      for (int i = 0; i < 60 && !got; i++) begin
         ph = m_pos % ST;
         rq = !issued && ph == 3;
         if (rq) issued = 1;
         drive(0, 1, 0, rq, 0, 5'd7, 5'd0, 5'(ph));
         sample();
         checks++; if (dout !== din) begin errors++; $display("FAIL read_dout got %h exp %h", dout, din); end
         if (busy) nb++;
         if (done) begin
            got = 1;
            checks++; if (rdata !== 5'd7 || rdata !== m_rdata) begin errors++; $display("FAIL read_rdata got %h exp 07", rdata); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL read_err got %b exp 0", err); end
         end
         tick();
      end
      checks++; if (!got || nb != 4) begin errors++; $display("FAIL read_busy_cycles got %0d done %0d exp 4 done 1", nb, got); end
   endtask

   task automatic test_write();
      logic [4:0] ring [ST];
      int ph, inj;
      bit got;
      for (int k = 0; k < ST; k++) ring[k] = 5'(k);
      for (int p = 0; p < 2; p++) begin
         got = 0; inj = 0;
         for (int i = 0; i < 40 && !got; i++) begin
            ph = m_pos % ST;
            drive(0, 1, 0, p == 1 && i == 0, p == 0 && i == 0, 5'd0, 5'h1F, ring[ph]);
            sample();
            checks++; if (dout !== e_dout) begin errors++; $display("FAIL write_dout got %h exp %h", dout, e_dout); end
            if (dout !== din) begin
               inj++;
               checks++; if (e_cur != 0 || dout !== 5'h1F) begin errors++; $display("FAIL write_inject slot %0d got %h exp slot 0 1f", e_cur, dout); end
            end
            if (clk_en) ring[e_cur] = dout;
            if (done && p == 1) begin
               checks++; if (rdata !== 5'h1F) begin errors++; $display("FAIL write_readback got %h exp 1f", rdata); end
            end
            if (done) got = 1;
            tick();
         end
         checks++; if (!got || inj != (p == 0 ? 1 : 0)) begin errors++; $display("FAIL write_done phase %0d got inj %0d done %0d exp inj %0d done 1", p, inj, got, p == 0 ? 1 : 0); end
      end
   endtask

   task automatic test_simul_bad();
      logic [4:0] old, wd;
      bit got;
      old = m_rdata; wd = 5'($urandom); got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         drive(0, 1, 0, i == 0, i == 0, 5'd2, wd, 5'($urandom));
         sample();
         checks++; if (dout !== e_dout) begin errors++; $display("FAIL simul_dout got %h exp %h", dout, e_dout); end
         if (done) begin
            got = 1;
            checks++; if (err !== 1'b0 || rdata !== old) begin errors++; $display("FAIL simul_done got err %b rdata %h exp err 0 rdata %h", err, rdata, old); end
         end
         tick();
      end
      checks++; if (!got) begin errors++; $display("FAIL simul_timeout got 0 exp 1"); end
      drive(0, 1, 0, 1, 0, 5'd30, 5'd0, 5'($urandom));
      sample();
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL bad_accept got busy %b done %b exp 0 0", busy, done); end
      tick();
      drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'($urandom));
      sample();
      checks++; if ({busy, done, err} !== 3'b011 || {busy, done, err} !== {e_busy, m_done, m_err}) begin errors++; $display("FAIL bad_err got %b exp 011", {busy, done, err}); end
      checks++; if (rdata !== old) begin errors++; $display("FAIL bad_rdata got %h exp %h", rdata, old); end
      tick();
      sample();
      checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL bad_pulse got %b exp 000", {busy, done, err}); end
      tick();
   endtask

   task automatic test_gaps();
      bit pe, got, rq, wq;
      int pc;
      pe = 0; pc = -1; got = 0;
      for (int i = 0; i < 120 && !got; i++) begin
         rq = i == 0 || (m_kind != 0 && $urandom_range(1) == 1);
         wq = i != 0 && m_kind != 0 && $urandom_range(3) == 0;
         drive(0, i % 3 == 0, 0, rq, wq, i == 0 ? 5'd5 : 5'($urandom), 5'($urandom), 5'($urandom));
         sample();
         checks++; if (busy !== e_busy) begin errors++; $display("FAIL gap_busy got %b exp %b", busy, e_busy); end
         checks++; if (done !== m_done) begin errors++; $display("FAIL gap_done got %b exp %b", done, m_done); end
         checks++; if (dout !== e_dout) begin errors++; $display("FAIL gap_dout got %h exp %h", dout, e_dout); end
         if (done) begin
            got = 1;
            checks++; if (!pe || pc != 5) begin errors++; $display("FAIL gap_match got en %b slot %0d exp en 1 slot 5", pe, pc); end
            checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL gap_rdata got %h exp %h", rdata, m_rdata); end
         end
         pe = clk_en; pc = e_cur;
         tick();
      end
      checks++; if (!got) begin errors++; $display("FAIL gap_timeout got 0 exp 1"); end
   endtask

   task automatic test_reset_midop();
      for (int i = 0; i < 30 && m_pos % ST != 2; i++) begin
         drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'($urandom)); sample(); tick();
      end
      drive(0, 1, 0, 0, 1, 5'd10, 5'h15, 5'd0); sample(); tick();
      for (int i = 0; i < 30 && m_pos % ST != 8; i++) begin
         drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'($urandom));
         sample();
         checks++; if (busy !== 1'b1 || dout !== din) begin errors++; $display("FAIL midop_pend got busy %b dout %h exp 1 %h", busy, dout, din); end
         tick();
      end
      drive(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      sample();
      checks++; if (dout !== {5{RV}}) begin errors++; $display("FAIL midop_rst_dout got %h exp %h", dout, {5{RV}}); end
      tick();
      for (int i = 0; i < 40; i++) begin
         drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'($urandom));
         sample();
         if (i == 0) begin
            checks++; if (dut.cnt_q !== 5'd0 || busy !== 1'b0) begin errors++; $display("FAIL midop_idle got cnt %0d busy %b exp 0 0", dut.cnt_q, busy); end
         end
         checks++; if (done !== 1'b0 || dout !== din) begin errors++; $display("FAIL midop_after got done %b dout %h exp 0 %h", done, dout, din); end
         tick();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         drive($urandom_range(299) == 0, $urandom_range(2) != 0, $urandom_range(39) == 0,
               $urandom_range(7) == 0, $urandom_range(7) == 0, 5'($urandom), 5'($urandom), 5'($urandom));
         sample();
         checks++; if (dout !== e_dout) begin errors++; $display("FAIL rand_dout cyc %0d got %h exp %h", i, dout, e_dout); end
         checks++; if ({busy, done, err} !== {e_busy, m_done, m_err}) begin errors++; $display("FAIL rand_flags cyc %0d got %b exp %b", i, {busy, done, err}, {e_busy, m_done, m_err}); end
         checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rand_rdata cyc %0d got %h exp %h", i, rdata, m_rdata); end
         tick();
      end
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      test_reset();
      test_slot_count();
      test_read();
      test_write();
      test_simul_bad();
      test_gaps();
      test_reset_midop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
